// File: rtl/cs_out_fifo.sv
// cs_out_fifo: output stage of the CS filter; drops the first WARMUP y_en samples, buffers the rest in a FWFT FIFO
// Ports: clk, reset (async, active-low), flush (sync clear), y_in/y_en (CS sample stream),
//        dout/dout_valid/dout_ready (valid/ready sink), full, empty, count (occupancy), overflow (sticky drop).
// Option: define CS_DROP_CNT_EN to add drop_cnt[7:0], a saturating count of dropped samples.
module cs_out_fifo #(
    parameter int DW     = 10,
    parameter int DEPTH  = 8,
    parameter int WARMUP = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [DW-1:0]          y_in,
    input  logic                   y_en,
    output logic [DW-1:0]          dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
`ifdef CS_DROP_CNT_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic [7:0] wc;
    logic warm, wr, rd, drop;
    assign warm       = wc == 8'(WARMUP);
    assign empty      = wp == rp;
    // extra pointer MSB distinguishes full from empty when the index bits match
    assign full       = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count      = wp - rp;
    assign dout_valid = !empty;
    // gated so dout reads 0 after reset instead of stale memory
    assign dout       = empty ? '0 : mem[rp[AW-1:0]];
    assign rd         = dout_valid & dout_ready;
    // a read in the same cycle frees a slot, so a full FIFO still accepts
    assign wr         = y_en & warm & (!full | rd);
    assign drop       = y_en & warm & full & !rd;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp       <= '0;
            rp       <= '0;
            wc       <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wp       <= '0;
            rp       <= '0;
            wc       <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
            if (y_en && !warm) wc <= wc + 8'd1;
            if (drop) overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (wr && !flush) mem[wp[AW-1:0]] <= y_in;
    end
`ifdef CS_DROP_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_cnt <= '0;
        else if (flush) drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif
endmodule
